// File: rtl/can_destuff_ctrl.sv
// Receive-side CAN bit destuffer: tracks bus idle / SOF and the equal-bit run,
// drops mandatory stuff bits, flags stuff errors and forwards data bits.
module can_destuff_ctrl #(
    parameter int STUFF_LEN = 5,
    parameter int IDLE_LEN  = 11
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Sample_Valid,
    input  logic       i_Rx_Bit,
    input  logic       i_Stuff_En,
    input  logic       i_Frame_End,
    output logic       o_Bit_Valid,
    output logic       o_Bit,
    output logic       o_Stuff_Drop,
    output logic       o_Stuff_Err,
    output logic       o_Bus_Idle,
    output logic       o_Busy,
    output logic [3:0] o_Run_Cnt
);

    localparam logic [3:0] RUN_MAX  = 4'(STUFF_LEN);
    localparam logic [3:0] IDLE_MAX = 4'(IDLE_LEN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_STUFF_CHK,
        ST_ERROR
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] idle_q, idle_d;
    logic [3:0] run_q, run_d;
    logic       last_q, last_d;
    logic       bit_q, bit_d;
    logic       bit_valid_q, bit_valid_d;
    logic       drop_q, drop_d;
    logic       err_q, err_d;
    logic       bus_idle_q, bus_idle_d;
    logic [3:0] idle_inc;
    logic [3:0] run_inc;

    // Saturating increments; a polarity change restarts the run at one.
    assign idle_inc = (idle_q == IDLE_MAX) ? idle_q : idle_q + 4'd1;
    assign run_inc  = (i_Rx_Bit != last_q) ? 4'd1 :
                      (run_q == RUN_MAX)   ? run_q : run_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        idle_d      = idle_q;
        run_d       = run_q;
        last_d      = last_q;
        bit_d       = bit_q;
        bit_valid_d = 1'b0;
        drop_d      = 1'b0;
        err_d       = 1'b0;
        bus_idle_d  = bus_idle_q;

        // Frame end outranks a coincident sample; in IDLE it is meaningless.
        if (i_Frame_End && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            run_d      = 4'd0;
            last_d     = 1'b1;
            idle_d     = 4'd0;
            bus_idle_d = 1'b0;
        end else if (i_Sample_Valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (i_Rx_Bit) begin
                        idle_d     = idle_inc;
                        bus_idle_d = (idle_inc == IDLE_MAX);
                    end else if (idle_q == IDLE_MAX) begin
                        bit_valid_d = 1'b1;
                        bit_d       = 1'b0;
                        run_d       = 4'd1;
                        last_d      = 1'b0;
                        idle_d      = 4'd0;
                        bus_idle_d  = 1'b0;
                        state_d     = ST_ACTIVE;
                    end else begin
                        idle_d = 4'd0;
                    end
                end
                ST_ACTIVE: begin
                    bit_valid_d = 1'b1;
                    bit_d       = i_Rx_Bit;
                    last_d      = i_Rx_Bit;
                    if (i_Stuff_En) begin
                        run_d = run_inc;
                        if (run_inc == RUN_MAX) state_d = ST_STUFF_CHK;
                    end else begin
                        run_d = 4'd0;
                    end
                end
                ST_STUFF_CHK: begin
                    // Checked even with destuffing disabled: the stuff bit
                    // after the last CRC bit must still be removed.
                    if (i_Rx_Bit != last_q) begin
                        drop_d  = 1'b1;
                        run_d   = 4'd1;
                        last_d  = i_Rx_Bit;
                        state_d = ST_ACTIVE;
                    end else begin
                        err_d   = 1'b1;
                        run_d   = 4'd0;
                        state_d = ST_ERROR;
                    end
                end
                ST_ERROR: begin
                    idle_d = i_Rx_Bit ? idle_inc : 4'd0;
                    if (i_Rx_Bit && (idle_inc == IDLE_MAX)) begin
                        state_d    = ST_IDLE;
                        bus_idle_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q     <= ST_IDLE;
            idle_q      <= 4'd0;
            run_q       <= 4'd0;
            last_q      <= 1'b1;
            bit_q       <= 1'b1;
            bit_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            err_q       <= 1'b0;
            bus_idle_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idle_q      <= idle_d;
            run_q       <= run_d;
            last_q      <= last_d;
            bit_q       <= bit_d;
            bit_valid_q <= bit_valid_d;
            drop_q      <= drop_d;
            err_q       <= err_d;
            bus_idle_q  <= bus_idle_d;
        end
    end

    assign o_Bit_Valid  = bit_valid_q;
    assign o_Bit        = bit_q;
    assign o_Stuff_Drop = drop_q;
    assign o_Stuff_Err  = err_q;
    assign o_Bus_Idle   = bus_idle_q;
    assign o_Busy       = (state_q == ST_ACTIVE) || (state_q == ST_STUFF_CHK);
    assign o_Run_Cnt    = run_q;

endmodule

// File: tb/tb_can_destuff_ctrl.sv
// Bench for can_destuff_ctrl: directed bus sequences checked every cycle
// against a queue-based model of the destuffing rules, plus literal pins.
module tb_can_destuff_ctrl;

    localparam int STUFF_LEN = 5;
    localparam int IDLE_LEN  = 11;

    localparam int M_IDLE  = 0;
    localparam int M_FRAME = 1;
    localparam int M_ERROR = 2;

    logic       i_Clock = 1'b0;
    logic       i_Reset = 1'b0;
    logic       i_Sample_Valid = 1'b0;
    logic       i_Rx_Bit = 1'b1;
    logic       i_Stuff_En = 1'b0;
    logic       i_Frame_End = 1'b0;
    logic       o_Bit_Valid;
    logic       o_Bit;
    logic       o_Stuff_Drop;
    logic       o_Stuff_Err;
    logic       o_Bus_Idle;
    logic       o_Busy;
    logic [3:0] o_Run_Cnt;

    int n_cmp = 0;
    int n_bad = 0;

    can_destuff_ctrl #(.STUFF_LEN(STUFF_LEN), .IDLE_LEN(IDLE_LEN)) dut (
        .i_Clock       (i_Clock),
        .i_Reset       (i_Reset),
        .i_Sample_Valid(i_Sample_Valid),
        .i_Rx_Bit      (i_Rx_Bit),
        .i_Stuff_En    (i_Stuff_En),
        .i_Frame_End   (i_Frame_End),
        .o_Bit_Valid   (o_Bit_Valid),
        .o_Bit         (o_Bit),
        .o_Stuff_Drop  (o_Stuff_Drop),
        .o_Stuff_Err   (o_Stuff_Err),
        .o_Bus_Idle    (o_Bus_Idle),
        .o_Busy        (o_Busy),
        .o_Run_Cnt     (o_Run_Cnt)
    );

    // ---------------- clock ----------------
    always #5 i_Clock = ~i_Clock;

    // ---------------- model ----------------
    // hist holds the current run of equal destuffed bits (its size is the run).
    int   m_mode;
    bit   hist[$];
    bit   m_last;
    int   m_ones;
    bit   m_bus_idle, m_bit, m_bv, m_drop, m_err;

    task automatic model_reset();
        m_mode = M_IDLE;
        hist.delete();
        m_last = 1'b1;
        m_ones = 0;
        m_bus_idle = 1'b0;
        m_bit = 1'b1;
        m_bv = 1'b0;
        m_drop = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_step();
        if (i_Reset) begin
            model_reset();
            return;
        end
        m_bv = 1'b0;
        m_drop = 1'b0;
        m_err = 1'b0;
        if (i_Frame_End && m_mode != M_IDLE) begin
            m_mode = M_IDLE;
            hist.delete();
            m_last = 1'b1;
            m_ones = 0;
            m_bus_idle = 1'b0;
        end else if (i_Sample_Valid) begin
            if (m_mode == M_IDLE) begin
                if (i_Rx_Bit) begin
                    if (m_ones < IDLE_LEN) m_ones++;
                    m_bus_idle = (m_ones == IDLE_LEN);
                end else if (m_ones == IDLE_LEN) begin
                    m_bv = 1'b1;
                    m_bit = 1'b0;
                    hist.delete();
                    hist.push_back(1'b0);
                    m_last = 1'b0;
                    m_ones = 0;
                    m_bus_idle = 1'b0;
                    m_mode = M_FRAME;
                end else begin
                    m_ones = 0;
                end
            end else if (m_mode == M_FRAME) begin
                if (hist.size() == STUFF_LEN) begin
                    if (i_Rx_Bit != m_last) begin
                        m_drop = 1'b1;
                        hist.delete();
                        hist.push_back(i_Rx_Bit);
                        m_last = i_Rx_Bit;
                    end else begin
                        m_err = 1'b1;
                        hist.delete();
                        m_mode = M_ERROR;
                    end
                end else begin
                    m_bv = 1'b1;
                    m_bit = i_Rx_Bit;
                    if (i_Stuff_En) begin
                        if (i_Rx_Bit != m_last) hist.delete();
                        hist.push_back(i_Rx_Bit);
                    end else begin
                        hist.delete();
                    end
                    m_last = i_Rx_Bit;
                end
            end else begin
                if (i_Rx_Bit) begin
                    if (m_ones < IDLE_LEN) m_ones++;
                end else begin
                    m_ones = 0;
                end
                if (m_ones == IDLE_LEN) begin
                    m_mode = M_IDLE;
                    m_bus_idle = 1'b1;
                end
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge i_Clock);
            check1("bit_valid", o_Bit_Valid, m_bv);
            check1("bit", o_Bit, m_bit);
            check1("stuff_drop", o_Stuff_Drop, m_drop);
            check1("stuff_err", o_Stuff_Err, m_err);
            check1("bus_idle", o_Bus_Idle, m_bus_idle);
            check1("busy", o_Busy, m_mode == M_FRAME);
            check4("run_cnt", o_Run_Cnt, 4'(hist.size()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge i_Clock);
        model_step();
        #1;
    endtask

    task automatic strobe(input logic b, input logic en);
        i_Sample_Valid = 1'b1;
        i_Rx_Bit = b;
        i_Stuff_En = en;
        tick();
        i_Sample_Valid = 1'b0;
    endtask

    task automatic recessive(input int n);
        for (int i = 0; i < n; i++) strobe(1'b1, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        #1 i_Reset = 1'b1;
        tick();
        tick();
        i_Reset = 1'b0;
        check1("reset bus_idle", o_Bus_Idle, 1'b0);
        check1("reset bit", o_Bit, 1'b1);
        check4("reset run", o_Run_Cnt, 4'd0);

        // bus idle detection and SOF
        recessive(IDLE_LEN - 1);
        check1("idle after 10", o_Bus_Idle, 1'b0);
        recessive(1);
        check1("idle after 11", o_Bus_Idle, 1'b1);
        strobe(1'b0, 1'b1);
        check1("sof valid", o_Bit_Valid, 1'b1);
        check1("sof bit", o_Bit, 1'b0);
        check1("sof busy", o_Busy, 1'b1);

        // stuff bit drop
        for (int i = 0; i < 4; i++) strobe(1'b0, 1'b1);
        check4("run at 5", o_Run_Cnt, 4'd5);
        strobe(1'b1, 1'b1);
        check1("drop pulse", o_Stuff_Drop, 1'b1);
        check1("drop no valid", o_Bit_Valid, 1'b0);
        strobe(1'b0, 1'b1);
        check1("post drop valid", o_Bit_Valid, 1'b1);
        check4("post drop run", o_Run_Cnt, 4'd1);
        i_Frame_End = 1'b1;
        tick();
        i_Frame_End = 1'b0;

        // stuff error, recovery via idle, new SOF
        recessive(IDLE_LEN);
        strobe(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) strobe(1'b0, 1'b1);
        strobe(1'b0, 1'b1);
        check1("err pulse", o_Stuff_Err, 1'b1);
        check1("err busy", o_Busy, 1'b0);
        recessive(IDLE_LEN - 1);
        check1("err not idle yet", o_Bus_Idle, 1'b0);
        recessive(1);
        check1("err to idle", o_Bus_Idle, 1'b1);
        strobe(1'b0, 1'b1);
        check1("resof valid", o_Bit_Valid, 1'b1);

        // stuff check survives enable drop; long runs with destuffing off
        for (int i = 0; i < 5; i++) strobe(1'b1, 1'b1);
        strobe(1'b0, 1'b0);
        check1("late drop", o_Stuff_Drop, 1'b1);
        for (int i = 0; i < 6; i++) strobe(1'b0, 1'b0);
        check1("en0 valid", o_Bit_Valid, 1'b1);
        check1("en0 no err", o_Stuff_Err, 1'b0);
        check4("en0 run", o_Run_Cnt, 4'd0);
        for (int i = 0; i < 6; i++) strobe(1'b1, 1'b0);

        // frame end coincident with a sample
        strobe(1'b0, 1'b1);
        strobe(1'b0, 1'b1);
        i_Frame_End = 1'b1;
        strobe(1'b0, 1'b1);
        i_Frame_End = 1'b0;
        check1("fe no valid", o_Bit_Valid, 1'b0);
        check1("fe busy", o_Busy, 1'b0);
        check4("fe run", o_Run_Cnt, 4'd0);
        check1("fe bus_idle", o_Bus_Idle, 1'b0);

        // asynchronous reset while a stuff check is pending
        recessive(IDLE_LEN);
        strobe(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) strobe(1'b0, 1'b1);
        check4("pre reset run", o_Run_Cnt, 4'd5);
        #2;
        i_Reset = 1'b1;
        model_reset();
        #1;
        check1("async busy", o_Busy, 1'b0);
        check4("async run", o_Run_Cnt, 4'd0);
        check1("async bit", o_Bit, 1'b1);
        check1("async bus_idle", o_Bus_Idle, 1'b0);
        tick();
        tick();
        i_Reset = 1'b0;
        strobe(1'b0, 1'b1);
        check1("no sof after reset", o_Bit_Valid, 1'b0);
        recessive(IDLE_LEN - 1);
        strobe(1'b0, 1'b1);
        check1("no sof short idle", o_Bit_Valid, 1'b0);
        recessive(IDLE_LEN);
        strobe(1'b0, 1'b1);
        check1("sof after idle", o_Bit_Valid, 1'b1);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
